// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// granting bursts of up to MAX_BURST beats and routing the late wr_ack back.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            req_accept,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [IDW-1:0]       ack_id_q;
  logic [3:0]           beat_q, beat_d;
  logic                 ack_pend_q;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic                 err_q;
  logic                 beat;
  logic [IDW-1:0]       pick;
  logic [IDW-1:0]       idx;
  logic                 pick_vld;

  // Search upward from last_q+1, wrapping, so the previous owner is tried last.
  always_comb begin
    pick     = '0;
    idx      = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((32'(last_q) + i) % 32'(NUM_REQ));
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    beat    = (state_q == BURST) && req[owner_q] && !fifo_full && !rst;
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          owner_d = pick;
          last_d  = pick;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (beat) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d = '0;
    if (state_d == BURST) gnt_d[owner_d] = 1'b1;

    req_accept = '0;
    if (beat) req_accept[owner_q] = 1'b1;

    fifo_wr_en   = beat;
    fifo_data_in = '0;
    req_ack_d    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (state_q == BURST && 32'(owner_q) == i)
        fifo_data_in = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      req_ack_d[i] = fifo_wr_ack && ack_pend_q && (32'(ack_id_q) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= IDW'(NUM_REQ - 1);
      beat_q     <= '0;
      gnt_q      <= '0;
      req_ack_q  <= '0;
      ack_pend_q <= 1'b0;
      ack_id_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      gnt_q      <= gnt_d;
      req_ack_q  <= req_ack_d;
      ack_pend_q <= beat;
      if (beat) ack_id_q <= owner_q;
      err_q      <= err_q | (ack_pend_q & ~fifo_wr_ack) | fifo_overflow;
    end
  end

  assign gnt     = gnt_q;
  assign req_ack = req_ack_q;
  assign err     = err_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one FIFO write interface among NUM_REQ requesters. Grants the port in bursts of up to MAX_BURST beats and never issues a write while the FIFO reports full. Routes the FIFO's one-cycle-late write acknowledge back to the originating requester, and flags any missing acknowledge or overflow. Sits directly in front of the FIFO write side, i.e. data_in, wr_en, full, wr_ack and overflow.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- FIFO_WIDTH, 16, data width; must equal the FIFO's data width
- MAX_BURST, 4, maximum beats per grant (1..15)
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester write request; held while the requester has data
- req_data  in  NUM_REQ*FIFO_WIDTH  requester i's data in bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- gnt  out  NUM_REQ  registered one-hot grant; all zeros when no owner
- req_accept  out  NUM_REQ  combinational; bit i = 1 when requester i's beat is taken this cycle
- req_ack  out  NUM_REQ  registered; FIFO wr_ack routed to the requester that wrote
- fifo_wr_en  out  1  combinational write enable to the FIFO
- fifo_data_in  out  FIFO_WIDTH  combinational data to the FIFO; equals the owner's slice, or 0 when idle
- fifo_full  in  1  FIFO full flag
- fifo_wr_ack  in  1  FIFO write acknowledge, arriving one cycle after a write
- fifo_overflow  in  1  FIFO overflow flag
- err  out  1  sticky error; cleared only by rst

## Operation
- States: IDLE, BURST. Registers: owner (clog2 NUM_REQ bits), last_owner, beat_cnt (4 bits), ack_pend, ack_id.
- IDLE with any req bit set:
  - Pick the first set bit searching upward from last_owner+1, wrapping modulo NUM_REQ.
  - Load owner and set last_owner = pick. Clear beat_cnt. Go to BURST.
  - No beat is transferred in IDLE.
- BURST: gnt = onehot(owner).
- Beat condition is req[owner] && !fifo_full. When it holds:
  - fifo_wr_en = 1 and fifo_data_in = owner's slice.
  - req_accept[owner] = 1 and beat_cnt increments.
- Exit BURST to IDLE (gnt clears next cycle) when either:
  - req[owner] = 0, in which case no beat occurs that cycle; or
  - a beat occurs with beat_cnt == MAX_BURST-1.
- Full stall: while fifo_full = 1, the owner keeps gnt, no beat occurs, and beat_cnt holds. The stall is unbounded.
- A requester whose req drops during its own stall loses the grant.
- Ack tracking:
  - On each beat, ack_pend <= 1 and ack_id <= owner; otherwise ack_pend <= 0.
  - req_ack[i] <= fifo_wr_ack && ack_pend && (ack_id == i). Note this is registered, so it lags fifo_wr_ack by one cycle.
- err is set when either:
  - ack_pend = 1 and fifo_wr_ack = 0 (missing acknowledge); or
  - fifo_overflow = 1, which must be impossible because writes are gated by full.
- Reset values: state IDLE, owner 0, last_owner NUM_REQ-1 (so requester 0 wins first), beat_cnt 0, gnt 0, req_ack 0, ack_pend 0, err 0.
- Reset while in BURST: the burst is abandoned, and fifo_wr_en is 0 in any cycle where rst = 1. A beat accepted in the cycle before rst is not acknowledged, and err is not set for it.

## Timing
- Arbitration latency: req rising in IDLE at cycle t gives gnt at t+1; the first beat can occur at t+1.
- Throughput: at most MAX_BURST beats per MAX_BURST+1 cycles, since there is one IDLE bubble per grant.
- Acknowledge: beat at cycle t; FIFO wr_ack at t+1; req_ack[owner] at t+2.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,... Worst-case wait is (NUM_REQ-1)*(MAX_BURST+1) cycles plus full stalls.
- fifo_wr_en, fifo_data_in and req_accept are combinational from state and owner registers, req, req_data and fifo_full. There is no path from fifo_wr_ack to fifo_wr_en.

## Test plan
- Single requester, requirement on the grant: rst, then req=4'b0100 held and FIFO empty. Required: gnt=4'b0100 one cycle later, followed by exactly 4 beats.
- Single requester, requirement on the bubble and acks: in the same run, gnt drops for 1 cycle after the 4 beats and then re-grants to requester 2. req_ack[2] pulses 2 cycles after each beat.
- All requesters, FIFO_DEPTH=8 with no reads: req=4'b1111 with data = requester id. Required: the first 8 FIFO writes come from ids 0,0,0,0,1,1,1,1. Requester 2 is then granted and stalled by fifo_full with no wr_en, and overflow and err stay 0.
- Full release: in that stalled state, drain one word. Required: requester 2 writes exactly one beat the cycle after full drops, and beat_cnt resumes from 0 so the burst ends after 4 total beats.
- Early release: grant requester 1 and drop req[1] after 2 beats. Required: IDLE next cycle, and the next pick is requester 2 even though req[0] is also set.
- Reset and error: assert rst in the middle of a burst. Required: fifo_wr_en=0 during rst and all outputs at reset values. Separately, force fifo_wr_ack=0 after a beat. Required: err=1 and it stays 1 until rst.
